// File: rtl/fp8_mul_host_if.sv
// Host-side pin interface for the FP8 multiplier tile: strobed operand writes,
// start/valid handshake with the core, and a held product plus status bits.
module fp8_mul_host_if #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] core_a,
   output logic [7:0] core_b,
   output logic       core_start,
   input  logic [7:0] core_result,
   input  logic       core_valid
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   wr;
   logic                   a_vld_q, b_vld_q;
   logic                   busy_q, done_q, err_q, timeout_q;
   logic [TW-1:0]          timer_q;
   logic                   timer_last;
   logic                   unused_pins;

   assign unused_pins = &{1'b0, uio_in[7:2]};

   // The synchronizer keeps shifting while ena is low; only the write is masked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], uio_in[0]};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign wr         = sync_q[SYNC_STAGES-1] & ~prev_q & ena;
   assign timer_last = (timer_q == TW'(TIMEOUT - 1));

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            IDLE:    if (a_vld_q && b_vld_q) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_valid || timer_last) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         uo_out    <= '0;
         core_a    <= '0;
         core_b    <= '0;
         a_vld_q   <= 1'b0;
         b_vld_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         timer_q   <= '0;
      end else if (ena) begin
         case (state_q)
            IDLE: begin
               if (wr && !uio_in[1]) begin
                  core_a    <= ui_in;
                  a_vld_q   <= 1'b1;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  timeout_q <= 1'b0;
               end else if (wr) begin
                  core_b  <= ui_in;
                  b_vld_q <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ISSUE: begin
               busy_q  <= 1'b1;
               a_vld_q <= 1'b0;
               b_vld_q <= 1'b0;
               timer_q <= '0;
               if (wr) err_q <= 1'b1;
            end
            WAIT: begin
               timer_q <= timer_q + TW'(1);
               // A result arriving on the last timer cycle still counts as success.
               if (core_valid) begin
                  uo_out <= core_result;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else if (timer_last) begin
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  timeout_q <= 1'b1;
               end
               if (wr) err_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Gating with ena holds a pending issue pulse until the tile is re-enabled.
   assign core_start = (state_q == ISSUE) && ena;
   assign uio_out    = {timeout_q, err_q, done_q, busy_q, 4'b0000};
   assign uio_oe     = 8'hF0;

endmodule
